// File: rtl/grid_io_bank_param_if.sv
// Pad-side and fabric-side data bundle of an I/O grid tile.
// The tile owns pad_out/pad_oe/io_inpad; the environment owns the rest.
interface grid_io_bank_param_if #(
    parameter int NUM_IO = 8
);
    logic [NUM_IO-1:0] gfpga_pad_iopad_pad_in;
    logic [NUM_IO-1:0] gfpga_pad_iopad_pad_out;
    logic [NUM_IO-1:0] gfpga_pad_iopad_pad_oe;
    logic [NUM_IO-1:0] io_outpad;
    logic [NUM_IO-1:0] io_inpad;

    modport master (
        output gfpga_pad_iopad_pad_in,
        output io_outpad,
        input  gfpga_pad_iopad_pad_out,
        input  gfpga_pad_iopad_pad_oe,
        input  io_inpad
    );

    modport slave (
        input  gfpga_pad_iopad_pad_in,
        input  io_outpad,
        output gfpga_pad_iopad_pad_out,
        output gfpga_pad_iopad_pad_oe,
        output io_inpad
    );
endinterface

// File: rtl/grid_io_bank_param.sv
// I/O grid tile: NUM_IO pad channels configured through a
// double-buffered scan chain with length-checked commit.
module grid_io_bank_param #(
    parameter int NUM_IO      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic prog_clk,
    input  logic pReset,
    input  logic ccff_head,
    input  logic ccff_en,
    input  logic ccff_commit,
    output logic ccff_tail,
    output logic cfg_loaded,
    output logic cfg_error,
    grid_io_bank_param_if.slave io
);
    localparam int CFG_W = 3 * NUM_IO;
    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CFG_N = CNT_W'(CFG_W);

    logic [CFG_W-1:0] sr_q, sr_d;
    logic [CFG_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             loaded_q, loaded_d;
    logic             err_q, err_d;
    logic [NUM_IO-1:0] out_q;
    logic [SYNC_STAGES-1:0][NUM_IO-1:0] sync_q;

    always_comb begin
        sr_d     = sr_q;
        act_d    = act_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        err_d    = err_q;
        if (ccff_en) begin
            sr_d     = {sr_q[CFG_W-2:0], ccff_head};
            loaded_d = 1'b0;
            if (cnt_q != CFG_N) cnt_d = cnt_q + CNT_W'(1);
            if (ccff_commit) err_d = 1'b1;
        end else if (ccff_commit) begin
            // Only a complete, freshly shifted frame may go live.
            if (cnt_q == CFG_N) begin
                act_d    = sr_q;
                cnt_d    = '0;
                loaded_d = 1'b1;
                err_d    = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            sr_q     <= '0;
            act_q    <= '0;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            out_q    <= '0;
            sync_q   <= '0;
        end else begin
            sr_q     <= sr_d;
            act_q    <= act_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            out_q    <= io.io_outpad;
            sync_q[0] <= io.gfpga_pad_iopad_pad_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign ccff_tail  = sr_q[CFG_W-1];
    assign cfg_loaded = loaded_q;
    assign cfg_error  = err_q;

    always_comb begin
        io.gfpga_pad_iopad_pad_oe  = '0;
        io.gfpga_pad_iopad_pad_out = '0;
        io.io_inpad                = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            io.gfpga_pad_iopad_pad_oe[k] = act_q[3*k];
            io.gfpga_pad_iopad_pad_out[k] = act_q[3*k] &
                (act_q[3*k+1] ? out_q[k] : io.io_outpad[k]);
            // Held low during reset so the fabric never sees raw pad noise.
            io.io_inpad[k] = pReset & ~act_q[3*k] &
                (act_q[3*k+2] ? sync_q[SYNC_STAGES-1][k]
                              : io.gfpga_pad_iopad_pad_in[k]);
        end
    end
endmodule

// File: tb/tb_grid_io_bank_param.sv
// Directed bench for grid_io_bank_param: two chained tiles,
// config load/commit rules and per-channel datapath modes.
module tb_grid_io_bank_param;
    localparam int N = 8;
    localparam logic [23:0] CFG1 = 24'h000119;
    localparam logic [47:0] PAT  = {24'hA49249, 24'h000119};

    logic prog_clk = 1'b0;
    logic pReset   = 1'b0;
    logic head     = 1'b0;
    logic en       = 1'b0;
    logic commit   = 1'b0;
    logic tail0, tail1, ld0, ld1, er0, er1;
    int   n_run  = 0;
    int   n_fail = 0;

    grid_io_bank_param_if #(.NUM_IO(N)) b0 ();
    grid_io_bank_param_if #(.NUM_IO(N)) b1 ();

    grid_io_bank_param #(.NUM_IO(N), .SYNC_STAGES(2)) u0 (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .ccff_head   (head),
        .ccff_en     (en),
        .ccff_commit (commit),
        .ccff_tail   (tail0),
        .cfg_loaded  (ld0),
        .cfg_error   (er0),
        .io          (b0.slave)
    );

    grid_io_bank_param #(.NUM_IO(N), .SYNC_STAGES(2)) u1 (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .ccff_head   (tail0),
        .ccff_en     (en),
        .ccff_commit (commit),
        .ccff_tail   (tail1),
        .cfg_loaded  (ld1),
        .cfg_error   (er1),
        .io          (b1.slave)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift(input logic [47:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            head = w[i];
            en   = 1'b1;
            tick();
        end
        en   = 1'b0;
        head = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        b0.gfpga_pad_iopad_pad_in = '0;
        b0.io_outpad              = '0;
        b1.gfpga_pad_iopad_pad_in = '0;
        b1.io_outpad              = '0;

        // reset held while inputs toggle
        for (int i = 0; i < 6; i++) begin
            head   = 1'($urandom_range(0, 1));
            en     = 1'($urandom_range(0, 1));
            commit = 1'($urandom_range(0, 1));
            b0.gfpga_pad_iopad_pad_in = 8'($urandom);
            b0.io_outpad              = 8'($urandom);
            tick();
        end
        chk("rst_oe", b0.gfpga_pad_iopad_pad_oe, 8'h00);
        chk("rst_pad_out", b0.gfpga_pad_iopad_pad_out, 8'h00);
        chk("rst_inpad", b0.io_inpad, 8'h00);
        chk("rst_tail", 8'(tail0), 8'h0);
        chk("rst_loaded", 8'(ld0), 8'h0);
        chk("rst_error", 8'(er0), 8'h0);
        head = 0; en = 0; commit = 0;
        b0.gfpga_pad_iopad_pad_in = '0;
        b0.io_outpad              = '0;
        pReset = 1'b1;
        tick();
        tick();

        // program ch0=001 ch1=011 ch2=100
        shift(48'(CFG1), 24);
        chk("prog_nocommit_oe", b0.gfpga_pad_iopad_pad_oe, 8'h00);
        do_commit();
        chk("prog_loaded", 8'(ld0), 8'h1);
        chk("prog_error", 8'(er0), 8'h0);
        chk("prog_oe", b0.gfpga_pad_iopad_pad_oe, 8'h03);
        b0.io_outpad = 8'h01;
        #1;
        chk("ch0_direct_hi", b0.gfpga_pad_iopad_pad_out, 8'h01);
        tick();
        b0.io_outpad = 8'h02;
        #1;
        chk("ch1_reg_t0", b0.gfpga_pad_iopad_pad_out, 8'h00);
        tick();
        chk("ch1_reg_t1", b0.gfpga_pad_iopad_pad_out, 8'h02);
        b0.io_outpad = 8'h00;
        #1;
        chk("ch1_reg_hold", b0.gfpga_pad_iopad_pad_out, 8'h02);
        tick();
        chk("ch1_reg_fall", b0.gfpga_pad_iopad_pad_out, 8'h00);
        b0.gfpga_pad_iopad_pad_in = 8'h04;
        #1;
        chk("ch2_sync_t0", b0.io_inpad, 8'h00);
        tick();
        chk("ch2_sync_t1", b0.io_inpad, 8'h00);
        tick();
        chk("ch2_sync_t2", b0.io_inpad, 8'h04);
        b0.gfpga_pad_iopad_pad_in = 8'h0D;
        #1;
        chk("inpad_mix", b0.io_inpad, 8'h0C);
        b0.gfpga_pad_iopad_pad_in = 8'h00;
        tick();
        tick();
        chk("inpad_clear", b0.io_inpad, 8'h00);

        // short load leaves act alone
        shift(48'hFFFFFF, 23);
        do_commit();
        chk("short_error", 8'(er0), 8'h1);
        chk("short_loaded", 8'(ld0), 8'h0);
        chk("short_oe", b0.gfpga_pad_iopad_pad_oe, 8'h03);
        b0.io_outpad = 8'h03;
        tick();
        chk("short_pad_out", b0.gfpga_pad_iopad_pad_out, 8'h03);

        // shift and commit together at cnt=23
        head = 1'b0; en = 1'b1; commit = 1'b1;
        tick();
        en = 1'b0; commit = 1'b0;
        chk("both_error", 8'(er0), 8'h1);
        chk("both_oe", b0.gfpga_pad_iopad_pad_oe, 8'h03);
        do_commit();
        chk("cnt24_loaded", 8'(ld0), 8'h1);
        chk("cnt24_error", 8'(er0), 8'h0);
        chk("cnt24_oe", b0.gfpga_pad_iopad_pad_oe, 8'hFE);
        chk("cnt24_pad_out", b0.gfpga_pad_iopad_pad_out, 8'h02);

        // shadow isolation
        shift(48'(CFG1), 24);
        do_commit();
        chk("iso_oe0", b0.gfpga_pad_iopad_pad_oe, 8'h03);
        b0.io_outpad = 8'h01;
        tick();
        for (int i = 0; i < 12; i++) begin
            head = 1'b1;
            en   = 1'b1;
            tick();
            chk("iso_oe", b0.gfpga_pad_iopad_pad_oe, 8'h03);
            chk("iso_pad_out", b0.gfpga_pad_iopad_pad_out, 8'h01);
        end
        en = 1'b0; head = 1'b0;
        chk("iso_loaded", 8'(ld0), 8'h0);

        // two-tile chain pass-through
        pReset = 1'b0;
        #2;
        pReset = 1'b1;
        chk("chain_rst_oe", b0.gfpga_pad_iopad_pad_oe, 8'h00);
        chk("chain_rst_tail1", 8'(tail1), 8'h0);
        for (int i = 47; i >= 0; i--) begin
            head = PAT[i];
            en   = 1'b1;
            tick();
            if (i == 25) chk("tail0_s23", 8'(tail0), 8'h0);
            if (i == 24) chk("tail0_s24", 8'(tail0), 8'h1);
            if (i == 1)  chk("tail1_s47", 8'(tail1), 8'h0);
            if (i == 0)  chk("tail1_s48", 8'(tail1), 8'h1);
        end
        en = 1'b0; head = 1'b0;
        do_commit();
        chk("chain_ld0", 8'(ld0), 8'h1);
        chk("chain_ld1", 8'(ld1), 8'h1);
        chk("chain_oe0", b0.gfpga_pad_iopad_pad_oe, 8'h03);
        chk("chain_oe1", b1.gfpga_pad_iopad_pad_oe, 8'hFF);

        // reset after 10 shifts discards the partial load
        shift(48'hFFFFFF, 10);
        pReset = 1'b0;
        #2;
        chk("midrst_oe", b0.gfpga_pad_iopad_pad_oe, 8'h00);
        chk("midrst_loaded", 8'(ld0), 8'h0);
        pReset = 1'b1;
        do_commit();
        chk("midrst_error", 8'(er0), 8'h1);
        chk("midrst_loaded2", 8'(ld0), 8'h0);
        chk("midrst_oe2", b0.gfpga_pad_iopad_pad_oe, 8'h00);
        chk("midrst_pad_out", b0.gfpga_pad_iopad_pad_out, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/grid_io_bank_param.md
Name: grid_io_bank_param

Overview:
- Parametrised I/O grid tile with NUM_IO pad channels and a double-buffered configuration chain.
- Each channel has a per-channel mode: input, direct output or registered output, with an optional input synchroniser.
- Configuration shifts in through ccff_head/ccff_tail. It takes effect only on an explicit, length-checked commit, so pads do not glitch while the chain is reprogrammed.
- Instantiated on fabric boundaries and chained tile-to-tile through ccff_tail -> ccff_head.

Parameters:
- NUM_IO, 8: number of pad channels. Range 1..64.
- SYNC_STAGES, 2: flop depth of the input synchroniser. Range 1..4.
- CFG_W: derived localparam, 3*NUM_IO. Configuration bits per tile (3 per channel).

Ports:
- prog_clk  in  1  single clock for configuration and datapath.
- pReset  in  1  asynchronous reset, active-low.
- ccff_head  in  1  serial configuration input.
- ccff_en  in  1  shift enable.
- ccff_commit  in  1  single-cycle pulse; copies shadow to active configuration.
- ccff_tail  out  1  serial configuration output; feeds the next tile.
- cfg_loaded  out  1  set after a valid commit.
- cfg_error  out  1  sticky error after an invalid commit.
- gfpga_pad_iopad_pad_in  in  NUM_IO  pad receive value.
- gfpga_pad_iopad_pad_out  out  NUM_IO  pad drive value.
- gfpga_pad_iopad_pad_oe  out  NUM_IO  pad output enable; 1 = drive.
- io_outpad  in  NUM_IO  fabric -> pad data.
- io_inpad  out  NUM_IO  pad -> fabric data.

Behaviour:
- Reset (pReset=0, async) clears to 0: shadow register sr[CFG_W-1:0], active config act, shift count cnt, out_q, all sync stages, cfg_loaded, cfg_error.
- Reset outputs: ccff_tail=0, all oe=0, all pad_out=0, all io_inpad=0.
- Reset mid-shift or mid-commit discards the partial load; no commit occurs.
- Shift, when ccff_en=1 on a rising edge:
  - sr[0]<=ccff_head; sr[i]<=sr[i-1].
  - ccff_tail = sr[CFG_W-1] (registered), so pass-through latency is exactly CFG_W cycles.
  - cnt increments, saturating at CFG_W.
  - cfg_loaded clears on the first shift.
  - act is unchanged while shifting.
- Channel k config bits: sr[3k] = dir (1=output), sr[3k+1] = reg_out, sr[3k+2] = reg_in. The first bit shifted in after CFG_W shifts lands in ch NUM_IO-1 reg_in.
- Commit, when ccff_commit=1 and ccff_en=0:
  - If cnt==CFG_W: act<=sr, cnt<=0, cfg_loaded<=1, cfg_error<=0. New mode is visible on outputs the cycle after the commit edge.
  - If cnt<CFG_W: act is unchanged, cfg_error<=1, cnt unchanged.
- ccff_commit and ccff_en both high in the same cycle: the shift happens, the commit is ignored, cfg_error<=1.
- A commit with sr unchanged since the last commit (cnt==0) counts as an error.
- Datapath, per channel k, using act:
  - out_q[k]<=io_outpad[k] every cycle, regardless of mode.
  - oe[k] = dir.
  - pad_out[k] = dir ? (reg_out ? out_q[k] : io_outpad[k]) : 0.
  - sync[k] is a SYNC_STAGES-deep shift of pad_in[k], free-running.
  - io_inpad[k] = dir ? 0 : (reg_in ? sync_last[k] : pad_in[k]).
- Latency:
  - Direct paths are combinational.
  - reg_out adds 1 cycle.
  - reg_in adds SYNC_STAGES cycles.
- No combinational path from ccff_head to ccff_tail.
- No combinational path from the config inputs (ccff_head, ccff_en, ccff_commit) to pad or fabric outputs.

Test Plan:
- Reset: pReset low while toggling all inputs -> oe=0, pad_out=0, io_inpad=0, ccff_tail=0, cfg_loaded=0, cfg_error=0.
- Program, NUM_IO=8:
  - Stimulus: shift 24 bits so ch0=dir (001), ch1=dir+reg_out (011), ch2=reg_in (100), others 000; then commit.
  - Expected: cfg_loaded=1; oe=8'b0000_0011.
  - ch0: pad_out follows io_outpad[0] in the same cycle.
  - ch1: pad_out lags io_outpad[1] by 1 cycle.
  - ch2: io_inpad lags pad_in[2] by 2 cycles.
- Short load: shift 23 bits then commit -> cfg_error=1, act unchanged, outputs identical to before.
- Shadow isolation: after a valid commit, shift 12 new bits without commit -> oe and pad_out unchanged throughout.
- Chain pass-through: shift a 48-bit pattern through two chained instances -> tail of instance 2 reproduces the first bit 48 cycles after entry. After a commit to both, each instance holds its own 24-bit segment.
- Reset mid-shift and simultaneous events:
  - Assert pReset after 10 shifts -> cnt=0; a following commit sets cfg_error, act stays 0.
  - ccff_en and ccff_commit together at cnt=23 -> cnt=24, cfg_error=1, no commit.
